// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: buffers one left/right pair and shifts it out MSB first
// on sd with the one-bit I2S delay, driven by an external clk-synchronous sck/ws.
`timescale 1ns/1ps
module i2s_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ws,
  output logic             sd,
  input  logic [WIDTH-1:0] input_l_tdata,
  input  logic [WIDTH-1:0] input_r_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic             underrun
);

  logic             sck_last_r, sck_last_s;
  logic             ws_last_r, ws_last_s;
  logic             buf_valid_r, buf_valid_s;
  logic             sd_r, sd_s;
  logic             underrun_r, underrun_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [WIDTH-1:0] rhold_r, rhold_s;
  logic [WIDTH-1:0] buf_l_r, buf_l_s;
  logic [WIDTH-1:0] buf_r_r, buf_r_s;
  logic             fall_s;
  logic             accept_s;

  // Next-state logic: pair buffer capture plus word load/shift on each sck fall
  always_comb begin
    fall_s      = sck_last_r & ~sck;
    accept_s    = input_tvalid & ~buf_valid_r;
    sck_last_s  = sck;
    ws_last_s   = ws_last_r;
    buf_valid_s = buf_valid_r;
    sd_s        = sd_r;
    underrun_s  = 1'b0;
    sreg_s      = sreg_r;
    rhold_s     = rhold_r;
    buf_l_s     = buf_l_r;
    buf_r_s     = buf_r_r;

    if (accept_s) begin
      buf_l_s     = input_l_tdata;
      buf_r_s     = input_r_tdata;
      buf_valid_s = 1'b1;
    end else begin
      buf_valid_s = buf_valid_r;
    end

    if (fall_s) begin
      // The bit leaving now is the previous word's LSB when ws has just toggled.
      sd_s = sreg_r[WIDTH-1];
      if (ws != ws_last_r) begin
        ws_last_s = ws;
        if (!ws) begin
          if (buf_valid_r) begin
            sreg_s      = buf_l_r;
            rhold_s     = buf_r_r;
            buf_valid_s = 1'b0;
          end else begin
            sreg_s     = '0;
            rhold_s    = '0;
            underrun_s = 1'b1;
          end
        end else begin
          sreg_s = rhold_r;
        end
      end else begin
        sreg_s = {sreg_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      sd_s = sd_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_last_r  <= 1'b0;
      ws_last_r   <= 1'b0;
      buf_valid_r <= 1'b0;
      sd_r        <= 1'b0;
      underrun_r  <= 1'b0;
      sreg_r      <= '0;
      rhold_r     <= '0;
      buf_l_r     <= '0;
      buf_r_r     <= '0;
    end else begin
      sck_last_r  <= sck_last_s;
      ws_last_r   <= ws_last_s;
      buf_valid_r <= buf_valid_s;
      sd_r        <= sd_s;
      underrun_r  <= underrun_s;
      sreg_r      <= sreg_s;
      rhold_r     <= rhold_s;
      buf_l_r     <= buf_l_s;
      buf_r_r     <= buf_r_s;
    end
  end

  assign input_tready = ~buf_valid_r;
  assign sd           = sd_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: models the sck/ws generator (prescale 1), decodes sd like an
// I2S receiver and scoreboards decoded words, tready and underrun against a pair-level model.
`timescale 1ns/1ps
module tb_i2s_tx;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             gen_rst;
  logic             sck;
  logic             ws;
  logic             sd;
  logic [WIDTH-1:0] input_l_tdata;
  logic [WIDTH-1:0] input_r_tdata;
  logic             input_tvalid;
  logic             input_tready;
  logic             underrun;

  typedef struct packed {
    logic             ch;
    logic [WIDTH-1:0] w;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_words  = 0;

  i2s_tx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .input_l_tdata(input_l_tdata),
    .input_r_tdata(input_r_tdata),
    .input_tvalid (input_tvalid),
    .input_tready (input_tready),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Generator: sck toggles every 2 clk; ws toggles on the sck fall ending each 16-bit slot.
  bit gen_half = 1'b0;
  int gen_bcnt = 0;
  initial begin
    sck = 1'b0;
    ws  = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_rst) begin
        sck = 1'b0; ws = 1'b0; gen_half = 1'b0; gen_bcnt = 0;
      end else begin
        if (gen_half) begin
          if (sck) begin
            sck = 1'b0;
            if (gen_bcnt == WIDTH-1) begin
              gen_bcnt = 0;
              ws = ~ws;
            end else begin
              gen_bcnt++;
            end
          end else begin
            sck = 1'b1;
          end
        end
        gen_half = ~gen_half;
      end
    end
  end

  // Model + monitor state
  logic             m_bv = 1'b0;
  logic [WIDTH-1:0] m_l, m_r;
  logic             m_sck_prev = 1'b0;
  logic             m_wsf_prev = 1'b0;
  logic             exp_under;
  int               skip = 0;
  logic             dec_sck_q = 1'b0;
  logic             dec_sd_q = 1'b0;
  logic             dec_ws_prev = 1'b0;
  logic [WIDTH-1:0] dec_acc = '0;
  logic             rst_q = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      exp_under = 1'b0;
      if (rst) begin
        m_bv       = 1'b0;
        m_sck_prev = 1'b0;
        check("rst_sd", {31'd0, sd}, 32'd0);
        exp_q.delete();
        if (gen_rst) begin
          exp_q.push_back({1'b0, 16'h0000});
          exp_q.push_back({1'b1, 16'h0000});
          skip        = 0;
          dec_ws_prev = 1'b0;
          dec_acc     = '0;
          m_wsf_prev  = 1'b0;
        end else begin
          skip = 1;
        end
      end else begin
        logic fall, left, bv_old;
        bv_old = m_bv;
        fall   = m_sck_prev && !sck;
        left   = fall && !ws && m_wsf_prev;
        if (left) begin
          if (bv_old) begin
            exp_q.push_back({1'b0, m_l});
            exp_q.push_back({1'b1, m_r});
            m_bv = 1'b0;
          end else begin
            exp_q.push_back({1'b0, 16'h0000});
            exp_q.push_back({1'b1, 16'h0000});
            exp_under = 1'b1;
          end
        end
        if (input_tvalid && !bv_old) begin
          m_l  = input_l_tdata;
          m_r  = input_r_tdata;
          m_bv = 1'b1;
        end
        if (fall) m_wsf_prev = ws;
        m_sck_prev = sck;
      end
      check("underrun", {31'd0, underrun}, {31'd0, exp_under});
      check("tready", {31'd0, input_tready}, {31'd0, ~m_bv});

      // Receiver: a bit sampled on a rise belongs to the slot of ws at the previous rise.
      if (!rst && !rst_q && sck && dec_sck_q)
        check("sd_stable_high", {31'd0, sd}, {31'd0, dec_sd_q});
      if (sck && !dec_sck_q) begin
        dec_acc = {dec_acc[WIDTH-2:0], sd};
        if (ws != dec_ws_prev) begin
          if (skip > 0) begin
            skip--;
          end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL word_unexpected: got ch=%0d 0x%0h, expected nothing at %0t",
                     dec_ws_prev, dec_acc, $time);
          end else begin
            word_t e;
            e = exp_q.pop_front();
            n_words++;
            check("word_ch", {31'd0, dec_ws_prev}, {31'd0, e.ch});
            check(dec_ws_prev ? "right_word" : "left_word", {16'd0, dec_acc}, {16'd0, e.w});
          end
        end
        dec_ws_prev = ws;
      end
      dec_sck_q = sck;
      dec_sd_q  = sd;
      rst_q     = rst;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    logic rdy;
    int   t;
    input_l_tdata = l;
    input_r_tdata = r;
    input_tvalid  = 1'b1;
    t = 0;
    forever begin
      rdy = input_tready;
      @(negedge clk);
      if (rdy) break;
      t++;
      if (t > 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no tready, expected accept within 400 clk");
        input_tvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_level(input logic v);
    int t;
    t = 0;
    while (ws !== v && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL ws_timeout: got ws=%0b, expected %0b within 400 clk", ws, v);
    end
  endtask

  task automatic wait_edge(input logic v);
    wait_level(~v);
    wait_level(v);
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; gen_rst = 1'b1; input_tvalid = 1'b0;
    input_l_tdata = '0; input_r_tdata = '0;
    idle(4);
    check("rst_tready", {31'd0, input_tready}, 32'd1);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0; gen_rst = 1'b0;

    send(16'hA5C3, 16'h1234);
    input_tvalid = 1'b0;
    idle(400);

    send(16'h8001, 16'h7FFE);
    send(16'hFFFF, 16'h0000);
    send(16'h0001, 16'h8000);
    input_tvalid = 1'b0;
    idle(400);

    idle(300);

    send(16'h0001, 16'h8000);
    input_tvalid = 1'b0;
    idle(300);

    for (int i = 0; i < 6; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom));
      input_tvalid = 1'b0;
      idle($urandom_range(0, 200));
    end
    idle(300);

    wait_edge(1'b0);
    send(16'hBEEF, 16'hCAFE);
    input_tvalid = 1'b0;
    wait_edge(1'b1);
    idle(24);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("post_rst_sd", {31'd0, sd}, 32'd0);
    check("post_rst_tready", {31'd0, input_tready}, 32'd1);
    wait_edge(1'b0);
    wait_edge(1'b1);
    send(16'h5A5A, 16'hC3C3);
    input_tvalid = 1'b0;
    idle(400);

    check("words_decoded_min", {31'd0, (n_words >= 30)}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
